sample_iter_msaa: RTL

Parametrised successor to the rasterizer's fixed single-sample iterator stage. Accepts one micropolygon plus its snapped bounding box from the bbox stage and walks the sample grid inside the box in raster order, one sample per cycle, toward the hash/sample stages. Adds two capabilities: a run-time MSAA step (1/2/4/8 samples per pixel axis) and a downstream ready/valid handshake. Upstream is stalled through halt_o while a box is being walked.

---
 rtl/sample_iter_msaa_if.sv | 40 ++++
 rtl/sample_iter_msaa.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/sample_iter_msaa_if.sv
// Upstream (triangle + box) and downstream (sample) signals of the MSAA sample iterator.
interface sample_iter_msaa_if #(
  parameter int unsigned SIGFIG   = 24,
  parameter int unsigned RADIX    = 10,
  parameter int unsigned VERTS    = 3,
  parameter int unsigned AXIS     = 3,
  parameter int unsigned COLORS   = 3,
  parameter int unsigned SS_W_MAX = 3
);
  localparam int unsigned TriW = VERTS * AXIS * SIGFIG;
  localparam int unsigned ColW = COLORS * SIGFIG;
  localparam int unsigned SsW  = $clog2(SS_W_MAX + 1);

  logic                  tri_valid_i;
  logic [TriW-1:0]       tri_i;
  logic [ColW-1:0]       color_i;
  logic [2*SIGFIG-1:0]   box_ll_i;
  logic [2*SIGFIG-1:0]   box_ur_i;
  logic [SsW-1:0]        ss_w_i;
  logic                  halt_o;
  logic                  sample_valid_o;
  logic                  sample_ready_i;
  logic [2*SIGFIG-1:0]   sample_o;
  logic [TriW-1:0]       tri_o;
  logic [ColW-1:0]       color_o;
  logic                  first_o;
  logic                  last_o;

  // Producer/consumer side (drives triangles, accepts samples).
  modport master (
    output tri_valid_i, tri_i, color_i, box_ll_i, box_ur_i, ss_w_i, sample_ready_i,
    input  halt_o, sample_valid_o, sample_o, tri_o, color_o, first_o, last_o
  );

  // Iterator side.
  modport slave (
    input  tri_valid_i, tri_i, color_i, box_ll_i, box_ur_i, ss_w_i, sample_ready_i,
    output halt_o, sample_valid_o, sample_o, tri_o, color_o, first_o, last_o
  );
endinterface

// File: rtl/sample_iter_msaa.sv
// Walks the sample grid inside a snapped bounding box in raster order, one sample per
// handshake, with a run-time MSAA step of 1 << (RADIX - ss_w).
module sample_iter_msaa #(
  parameter int unsigned SIGFIG   = 24,
  parameter int unsigned RADIX    = 10,
  parameter int unsigned VERTS    = 3,
  parameter int unsigned AXIS     = 3,
  parameter int unsigned COLORS   = 3,
  parameter int unsigned SS_W_MAX = 3
) (
  input logic               clk,
  input logic               rst_n,
  sample_iter_msaa_if.slave bus
);
  localparam int unsigned TriW = VERTS * AXIS * SIGFIG;
  localparam int unsigned ColW = COLORS * SIGFIG;
  localparam int unsigned SsW  = $clog2(SS_W_MAX + 1);
  localparam int unsigned ShW  = $clog2(RADIX + 1);

  typedef enum logic {StIdle, StIter} state_e;

  state_e                    state_q, state_d;
  logic                      halt_q, halt_d;
  logic                      valid_q, valid_d;
  logic                      first_q, first_d;
  logic [TriW-1:0]           tri_q, tri_d;
  logic [ColW-1:0]           color_q, color_d;
  logic signed [SIGFIG-1:0]  x_q, x_d, y_q, y_d;
  logic signed [SIGFIG-1:0]  ll_x_q, ll_x_d, ur_x_q, ur_x_d, ur_y_q, ur_y_d;
  logic [SsW-1:0]            ssw_q, ssw_d;

  logic signed [SIGFIG-1:0]  in_ll_x, in_ll_y, in_ur_x, in_ur_y;
  logic                      box_ok, accept, fire;
  logic [31:0]               ss_ext;
  logic [SsW-1:0]            ss_clamp;
  logic [ShW-1:0]            sh;
  logic signed [SIGFIG:0]    step, nx, ny;
  logic                      x_wrap, y_wrap;

  // Input decode, clamp and next-coordinate arithmetic; one extra bit so x+step never wraps.
  always_comb begin
    in_ll_x  = bus.box_ll_i[SIGFIG-1:0];
    in_ll_y  = bus.box_ll_i[2*SIGFIG-1:SIGFIG];
    in_ur_x  = bus.box_ur_i[SIGFIG-1:0];
    in_ur_y  = bus.box_ur_i[2*SIGFIG-1:SIGFIG];
    box_ok   = (in_ll_x <= in_ur_x) && (in_ll_y <= in_ur_y);
    accept   = bus.tri_valid_i && !halt_q;
    fire     = valid_q && bus.sample_ready_i;
    ss_ext   = 32'(bus.ss_w_i);
    ss_clamp = (ss_ext > SS_W_MAX) ? SsW'(SS_W_MAX) : bus.ss_w_i;
    sh       = ShW'(RADIX) - ShW'(ssw_q);
    step     = (SIGFIG+1)'(1) << sh;
    nx       = {x_q[SIGFIG-1], x_q} + step;
    ny       = {y_q[SIGFIG-1], y_q} + step;
    x_wrap   = nx > {ur_x_q[SIGFIG-1], ur_x_q};
    y_wrap   = ny > {ur_y_q[SIGFIG-1], ur_y_q};
  end

  // Next-state: latch the triangle on accept, then step the grid on each fire.
  always_comb begin
    state_d = state_q;
    first_d = first_q;
    tri_d   = tri_q;
    color_d = color_q;
    x_d     = x_q;
    y_d     = y_q;
    ll_x_d  = ll_x_q;
    ur_x_d  = ur_x_q;
    ur_y_d  = ur_y_q;
    ssw_d   = ssw_q;
    case (state_q)
      StIdle: begin
        // An empty box is consumed without producing samples.
        if (accept && box_ok) begin
          state_d = StIter;
          first_d = 1'b1;
          tri_d   = bus.tri_i;
          color_d = bus.color_i;
          x_d     = in_ll_x;
          y_d     = in_ll_y;
          ll_x_d  = in_ll_x;
          ur_x_d  = in_ur_x;
          ur_y_d  = in_ur_y;
          ssw_d   = ss_clamp;
        end
      end
      StIter: begin
        if (fire) begin
          first_d = 1'b0;
          if (!x_wrap) begin
            x_d = nx[SIGFIG-1:0];
          end else if (!y_wrap) begin
            x_d = ll_x_q;
            y_d = ny[SIGFIG-1:0];
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    halt_d  = (state_d == StIter);
    valid_d = (state_d == StIter);
  end

  // State and data registers; reset clears everything, aborting any walk in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      halt_q  <= 1'b0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      tri_q   <= '0;
      color_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      ll_x_q  <= '0;
      ur_x_q  <= '0;
      ur_y_q  <= '0;
      ssw_q   <= '0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      valid_q <= valid_d;
      first_q <= first_d;
      tri_q   <= tri_d;
      color_q <= color_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ll_x_q  <= ll_x_d;
      ur_x_q  <= ur_x_d;
      ur_y_q  <= ur_y_d;
      ssw_q   <= ssw_d;
    end
  end

  // Outputs; last_o looks one step ahead in both axes.
  always_comb begin
    bus.halt_o         = halt_q;
    bus.sample_valid_o = valid_q;
    bus.sample_o       = {y_q, x_q};
    bus.tri_o          = tri_q;
    bus.color_o        = color_q;
    bus.first_o        = first_q;
    bus.last_o         = valid_q && x_wrap && y_wrap;
  end
endmodule
